// File: rtl/ula_seq_if.sv
// Handshake bundle for ula_seq: operand/op channel in, registered result/flag channel out.
interface ula_seq_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [2:0]       ULAControl;
    logic             InValid;
    logic             InReady;
    logic [WIDTH-1:0] ULAResult;
    logic             Flag_z;
    logic             CarryOut;
    logic             Flag_v;
    logic             Flag_n;
    logic             OutValid;
    logic             OutReady;

    modport master (
        output SrcA, SrcB, ULAControl, InValid, OutReady,
        input  InReady, ULAResult, Flag_z, CarryOut, Flag_v, Flag_n, OutValid
    );

    modport slave (
        input  SrcA, SrcB, ULAControl, InValid, OutReady,
        output InReady, ULAResult, Flag_z, CarryOut, Flag_v, Flag_n, OutValid
    );
endinterface

// File: rtl/ula_seq.sv
// Registered ALU with valid/ready handshakes on both sides.
// Define ULA_MUL_EN to build the multi-cycle shift-add multiply for code 111.
module ula_seq #(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic     clk,
    input  logic     rst_n,
    ula_seq_if.slave bus
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             c;
        logic             v;
    } alu_t;

    function automatic alu_t alu_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    input logic [2:0] op);
        logic [WIDTH:0] ext;
        alu_t           o;
        ext = '0;
        o   = '0;
        case (op)
            OP_ADD: begin
                ext   = {1'b0, a} + {1'b0, b};
                o.res = ext[WIDTH-1:0];
                o.c   = ext[WIDTH];
                o.v   = (a[WIDTH-1] == b[WIDTH-1]) && (ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                ext   = {1'b0, a} - {1'b0, b};
                o.res = ext[WIDTH-1:0];
                o.c   = ext[WIDTH];
                o.v   = (a[WIDTH-1] != b[WIDTH-1]) && (ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: o.res = a & b;
            OP_OR:  o.res = a | b;
            OP_XOR: o.res = a ^ b;
            OP_SLT: o.res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL: begin
                // The bit landing in position WIDTH is the last one shifted out.
                ext   = {1'b0, a} << b[SHW-1:0];
                o.res = ext[WIDTH-1:0];
                o.c   = ext[WIDTH];
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    alu_t             alu_p0;
    alu_t             ld_p0;
    logic             ld_en;
    logic             in_ready;
    logic             accept;
    logic [WIDTH-1:0] res_p1;
    logic             c_p1, v_p1, z_p1, n_p1;
    logic             vld_p1;

    assign alu_p0 = alu_op(bus.SrcA, bus.SrcB, bus.ULAControl);
    assign accept = bus.InValid && in_ready;

`ifdef ULA_MUL_EN
    typedef enum logic {IDLE, MUL} state_t;

    state_t             state, state_nxt;
    logic               is_mul;
    logic               mul_done;
    logic [2*WIDTH-1:0] mcand, acc, acc_nxt;
    logic [WIDTH-1:0]   mplier;
    logic [SHW-1:0]     cnt;
    alu_t               mul_p0;

    assign is_mul = (bus.ULAControl == 3'b111);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && is_mul) state_nxt = MUL;
            MUL:     if (mul_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        mul_done = 1'b0;
        case (state)
            IDLE:    in_ready = rst_n && (!vld_p1 || bus.OutReady);
            MUL:     mul_done = (cnt == SHW'(WIDTH - 1));
            default: in_ready = 1'b0;
        endcase
    end

    // Shift-add step: multiplier LSB gates the shifted multiplicand into the accumulator.
    assign acc_nxt    = acc + (mplier[0] ? mcand : '0);
    assign mul_p0.res = acc_nxt[WIDTH-1:0];
    assign mul_p0.c   = |acc_nxt[2*WIDTH-1:WIDTH];
    assign mul_p0.v   = 1'b0;

    always_ff @(posedge clk) begin
        if (accept && is_mul) begin
            mcand  <= {{WIDTH{1'b0}}, bus.SrcA};
            mplier <= bus.SrcB;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == MUL) begin
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            acc    <= acc_nxt;
            cnt    <= cnt + 1'b1;
        end
    end

    assign ld_en = (accept && !is_mul) || mul_done;
    assign ld_p0 = mul_done ? mul_p0 : alu_p0;
`else
    assign in_ready = rst_n && (!vld_p1 || bus.OutReady);
    assign ld_en    = accept;
    assign ld_p0    = alu_p0;
`endif

    // Stage p1: result register, held until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_p1 <= '0;
            c_p1   <= 1'b0;
            v_p1   <= 1'b0;
            z_p1   <= 1'b0;
            n_p1   <= 1'b0;
            vld_p1 <= 1'b0;
        end else if (ld_en) begin
            res_p1 <= ld_p0.res;
            c_p1   <= ld_p0.c;
            v_p1   <= ld_p0.v;
            z_p1   <= ~|ld_p0.res;
            n_p1   <= ld_p0.res[WIDTH-1];
            vld_p1 <= 1'b1;
        end else if (vld_p1 && bus.OutReady) begin
            vld_p1 <= 1'b0;
        end
    end

    assign bus.InReady   = in_ready;
    assign bus.ULAResult = res_p1;
    assign bus.CarryOut  = c_p1;
    assign bus.Flag_v    = v_p1;
    assign bus.Flag_z    = z_p1;
    assign bus.Flag_n    = n_p1;
    assign bus.OutValid  = vld_p1;
endmodule
